// File: rtl/pulse_sequencer_mc_if.sv
// rtl/pulse_sequencer_mc_if.sv - symbol memory write bus for pulse_sequencer_mc
//
// Purpose: carries the shared symbol memory write port into the sequencer core.
// Signals:
//   mem_we     write strobe
//   mem_waddr  write address (AW bits)
//   mem_wdata  symbol word: [SW-1]=level, [DUR_W-1:0]=duration
// Modports: master drives the bus, slave (the sequencer) receives it.

interface pulse_sequencer_mc_if #(
  parameter int DEPTH = 32,
  parameter int DUR_W = 8
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = DUR_W + 1;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [SW-1:0] mem_wdata;

  modport master (output mem_we, mem_waddr, mem_wdata);
  modport slave  (input  mem_we, mem_waddr, mem_wdata);
endinterface

// File: rtl/pulse_sequencer_mc.sv
// rtl/pulse_sequencer_mc.sv - multi-channel symbol pulse sequencer with shared memory
//
// Purpose: NUM_CH independent sequencers play symbol windows from one shared
// register-array symbol memory, with looping, per-channel prescaler, optional
// carrier gating, inversion and idle level.
// Optional feature macro: PULSE_SEQ_DEBUG_EN (exposes pc / loops remaining).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   mem_bus (slave)      symbol memory write port
//   ch_start / ch_stop   per-channel start / stop requests
//   ch_start_idx, ch_end_idx, ch_loop_idx, ch_loop_count, ch_loop_forever
//                        per-channel symbol window and loop control
//   ch_presc             per-channel prescaler exponent
//   ch_carrier_en, ch_carrier_half   carrier gating enable / shared half-period-1
//   ch_invert, ch_idle_level         output polarity and idle level
//   pulse_out            registered channel outputs
//   ch_busy, ch_valid, ch_done, ch_loop   channel status and event pulses
//   dbg_pc, dbg_loops    debug view (zero unless PULSE_SEQ_DEBUG_EN)

module pulse_sequencer_mc #(
  parameter  int NUM_CH  = 2,
  parameter  int DEPTH   = 32,
  parameter  int DUR_W   = 8,
  parameter  int PRESC_W = 4,
  parameter  int CAR_W   = 16,
  localparam int AW      = $clog2(DEPTH),
  localparam int SW      = DUR_W + 1,
  localparam int TW      = DUR_W + (1 << PRESC_W)
) (
  input  logic                      clk,
  input  logic                      rst,
  pulse_sequencer_mc_if.slave       mem_bus,
  input  logic [NUM_CH-1:0]         ch_start,
  input  logic [NUM_CH-1:0]         ch_stop,
  input  logic [NUM_CH*AW-1:0]      ch_start_idx,
  input  logic [NUM_CH*AW-1:0]      ch_end_idx,
  input  logic [NUM_CH*AW-1:0]      ch_loop_idx,
  input  logic [NUM_CH*8-1:0]       ch_loop_count,
  input  logic [NUM_CH-1:0]         ch_loop_forever,
  input  logic [NUM_CH*PRESC_W-1:0] ch_presc,
  input  logic [NUM_CH-1:0]         ch_carrier_en,
  input  logic [CAR_W-1:0]          ch_carrier_half,
  input  logic [NUM_CH-1:0]         ch_invert,
  input  logic [NUM_CH-1:0]         ch_idle_level,
  output logic [NUM_CH-1:0]         pulse_out,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH-1:0]         ch_valid,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [NUM_CH-1:0]         ch_loop,
  output logic [NUM_CH*AW-1:0]      dbg_pc,
  output logic [NUM_CH*8-1:0]       dbg_loops
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  logic [SW-1:0]    mem [DEPTH];

  state_t           st_q      [NUM_CH];
  state_t           st_d      [NUM_CH];
  logic [AW-1:0]    pc_q      [NUM_CH];
  logic [AW-1:0]    pc_d      [NUM_CH];
  logic [7:0]       loops_q   [NUM_CH];
  logic [7:0]       loops_d   [NUM_CH];
  logic [TW-1:0]    tick_q    [NUM_CH];
  logic [TW-1:0]    tick_d    [NUM_CH];
  logic [TW-1:0]    len_q     [NUM_CH];   // symbol length minus 1, captured at fetch
  logic [TW-1:0]    len_d     [NUM_CH];
  logic [CAR_W-1:0] car_cnt_q [NUM_CH];
  logic [CAR_W-1:0] car_cnt_d [NUM_CH];
  logic [SW-1:0]    fsym      [NUM_CH];
  logic [NUM_CH-1:0] lvl_q, lvl_d, car_ph_q, car_ph_d;
  logic [NUM_CH-1:0] fetch, done_c, loop_c, out_d;

  always_ff @(posedge clk) begin
    if (mem_bus.mem_we) mem[mem_bus.mem_waddr] <= mem_bus.mem_wdata;
  end

  always_comb begin
    fetch  = '0;
    done_c = '0;
    loop_c = '0;
    lvl_d    = lvl_q;
    car_ph_d = car_ph_q;
    out_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]      = st_q[c];
      pc_d[c]      = pc_q[c];
      loops_d[c]   = loops_q[c];
      tick_d[c]    = tick_q[c];
      len_d[c]     = len_q[c];
      car_cnt_d[c] = car_cnt_q[c];
      case (st_q[c])
        S_IDLE: if (ch_start[c]) st_d[c] = S_LOAD;
        S_LOAD: begin
          st_d[c]      = S_RUN;
          pc_d[c]      = ch_start_idx[c*AW +: AW];
          loops_d[c]   = ch_loop_count[c*8 +: 8];
          tick_d[c]    = '0;
          car_cnt_d[c] = '0;
          car_ph_d[c]  = 1'b1;
          fetch[c]     = 1'b1;
        end
        S_RUN: begin
          // Carrier phase runs continuously across symbol boundaries.
          if (car_cnt_q[c] == ch_carrier_half) begin
            car_cnt_d[c] = '0;
            car_ph_d[c]  = ~car_ph_q[c];
          end else begin
            car_cnt_d[c] = car_cnt_q[c] + CAR_W'(1);
          end
          if (tick_q[c] == len_q[c]) begin
            tick_d[c] = '0;
            if (pc_q[c] != ch_end_idx[c*AW +: AW]) begin
              pc_d[c]  = pc_q[c] + AW'(1);
              fetch[c] = 1'b1;
            end else if (ch_loop_forever[c] || (loops_q[c] != 8'd0)) begin
              pc_d[c] = ch_loop_idx[c*AW +: AW];
              if (!ch_loop_forever[c]) loops_d[c] = loops_q[c] - 8'd1;
              loop_c[c] = 1'b1;
              fetch[c]  = 1'b1;
            end else begin
              done_c[c] = 1'b1;
              st_d[c]   = S_IDLE;
            end
          end else begin
            tick_d[c] = tick_q[c] + TW'(1);
          end
        end
        default: st_d[c] = S_IDLE;
      endcase
      // Stop overrides everything, including a same-cycle completion.
      if (ch_stop[c]) begin
        st_d[c]    = S_IDLE;
        pc_d[c]    = pc_q[c];
        loops_d[c] = loops_q[c];
        fetch[c]   = 1'b0;
        done_c[c]  = 1'b0;
        loop_c[c]  = 1'b0;
      end
      // Symbol is captured at fetch so a concurrent memory write only affects later fetches.
      fsym[c] = mem[pc_d[c]];
      if (fetch[c]) begin
        lvl_d[c] = fsym[c][SW-1];
        len_d[c] = ((TW'(fsym[c][DUR_W-1:0]) + TW'(1)) << ch_presc[c*PRESC_W +: PRESC_W]) - TW'(1);
      end
      // Output is computed from next-cycle state so it lines up with ch_valid.
      out_d[c] = ((st_d[c] == S_RUN) ? (lvl_d[c] & (car_ph_d[c] | ~ch_carrier_en[c]))
                                     : ch_idle_level[c]) ^ ch_invert[c];
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst) begin
        st_q[c]      <= S_IDLE;
        pc_q[c]      <= '0;
        loops_q[c]   <= '0;
        tick_q[c]    <= '0;
        len_q[c]     <= '0;
        car_cnt_q[c] <= '0;
        lvl_q[c]     <= 1'b0;
        car_ph_q[c]  <= 1'b0;
        pulse_out[c] <= ch_idle_level[c] ^ ch_invert[c];
      end else begin
        st_q[c]      <= st_d[c];
        pc_q[c]      <= pc_d[c];
        loops_q[c]   <= loops_d[c];
        tick_q[c]    <= tick_d[c];
        len_q[c]     <= len_d[c];
        car_cnt_q[c] <= car_cnt_d[c];
        lvl_q[c]     <= lvl_d[c];
        car_ph_q[c]  <= car_ph_d[c];
        pulse_out[c] <= out_d[c];
      end
    end
  end

  always_comb begin
    ch_busy  = '0;
    ch_valid = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_busy[c]  = (st_q[c] != S_IDLE);
      ch_valid[c] = (st_q[c] == S_RUN);
    end
  end

  assign ch_done = done_c & {NUM_CH{~rst}};
  assign ch_loop = loop_c & {NUM_CH{~rst}};

`ifdef PULSE_SEQ_DEBUG_EN
  always_comb begin
    dbg_pc    = '0;
    dbg_loops = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      dbg_pc[c*AW +: AW]   = pc_q[c];
      dbg_loops[c*8 +: 8]  = loops_q[c];
    end
  end
`else
  assign dbg_pc    = '0;
  assign dbg_loops = '0;
`endif

endmodule

// File: tb/tb_pulse_sequencer_mc.sv
// tb/tb_pulse_sequencer_mc.sv - self-checking bench for pulse_sequencer_mc
module tb_pulse_sequencer_mc;
  localparam int NUM_CH = 2, DEPTH = 32, DUR_W = 8, PRESC_W = 4, CAR_W = 16;
  localparam int AW = 5, SW = 9;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_sequencer_mc_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) mbus ();

  logic [NUM_CH-1:0]         ch_start, ch_stop, ch_loop_forever, ch_carrier_en, ch_invert, ch_idle_level;
  logic [NUM_CH*AW-1:0]      ch_start_idx, ch_end_idx, ch_loop_idx;
  logic [NUM_CH*8-1:0]       ch_loop_count;
  logic [NUM_CH*PRESC_W-1:0] ch_presc;
  logic [CAR_W-1:0]          ch_carrier_half;
  logic [NUM_CH-1:0]         pulse_out, ch_busy, ch_valid, ch_done, ch_loop;
  logic [NUM_CH*AW-1:0]      dbg_pc;
  logic [NUM_CH*8-1:0]       dbg_loops;

  pulse_sequencer_mc #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DUR_W(DUR_W), .PRESC_W(PRESC_W), .CAR_W(CAR_W)) dut (
    .clk(clk), .rst(rst), .mem_bus(mbus),
    .ch_start(ch_start), .ch_stop(ch_stop), .ch_start_idx(ch_start_idx), .ch_end_idx(ch_end_idx),
    .ch_loop_idx(ch_loop_idx), .ch_loop_count(ch_loop_count), .ch_loop_forever(ch_loop_forever),
    .ch_presc(ch_presc), .ch_carrier_en(ch_carrier_en), .ch_carrier_half(ch_carrier_half),
    .ch_invert(ch_invert), .ch_idle_level(ch_idle_level), .pulse_out(pulse_out), .ch_busy(ch_busy),
    .ch_valid(ch_valid), .ch_done(ch_done), .ch_loop(ch_loop), .dbg_pc(dbg_pc), .dbg_loops(dbg_loops)
  );

  typedef struct {
    logic start;
    logic exp_pulse;
    logic exp_valid;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  vec_t vecs [16];
  int checks = 0;
  int errors = 0;
  logic [31:0] pat, bpat;
  int nv, nl, nd, nd1, dcyc;
  int epc [10] = '{30, 31, 31, 0, 0, 0, 1, 1, 1, 1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic lv, input int d);
    mbus.mem_we    = 1'b1;
    mbus.mem_waddr = AW'(a);
    mbus.mem_wdata = {lv, DUR_W'(d)};
    nxt();
    mbus.mem_we    = 1'b0;
  endtask

  task automatic cfg(input int c, input int s, input int e, input int l, input int cnt, input logic fe,
                     input int pr, input logic ce, input logic inv, input logic idl);
    ch_start_idx[c*AW +: AW]       = AW'(s);
    ch_end_idx[c*AW +: AW]         = AW'(e);
    ch_loop_idx[c*AW +: AW]        = AW'(l);
    ch_loop_count[c*8 +: 8]        = 8'(cnt);
    ch_loop_forever[c]             = fe;
    ch_presc[c*PRESC_W +: PRESC_W] = PRESC_W'(pr);
    ch_carrier_en[c]               = ce;
    ch_invert[c]                   = inv;
    ch_idle_level[c]               = idl;
  endtask

  initial begin
    // Timing window: mem0={1,3}, mem1={0,1}, presc=1 -> 8 high, 4 low from T+2.
    for (int i = 0; i < 16; i++) begin
      vecs[i].start     = (i == 0);
      vecs[i].exp_pulse = (i >= 2 && i <= 9);
      vecs[i].exp_valid = (i >= 2 && i <= 13);
      vecs[i].exp_busy  = (i >= 1 && i <= 13);
      vecs[i].exp_done  = (i == 13);
    end

    mbus.mem_we = 1'b0; mbus.mem_waddr = '0; mbus.mem_wdata = '0;
    ch_start = '0; ch_stop = '0; ch_start_idx = '0; ch_end_idx = '0; ch_loop_idx = '0;
    ch_loop_count = '0; ch_loop_forever = '0; ch_presc = '0; ch_carrier_en = '0;
    ch_carrier_half = '0; ch_invert = 2'b10; ch_idle_level = 2'b01;
    rst = 1'b1;
    nxt(); nxt();
    @(negedge clk);
    check("rst_pulse", pulse_out, 2'b11);
    check("rst_busy", ch_busy, 0);
    check("rst_valid", ch_valid, 0);
    check("rst_done", ch_done, 0);
    check("rst_dbg_pc", dbg_pc, 0);
    check("rst_dbg_loops", dbg_loops, 0);
    nxt();
    rst = 1'b0;
    ch_invert = '0; ch_idle_level = '0;

    wr(0, 1'b1, 3); wr(1, 1'b0, 1); wr(2, 1'b1, 0); wr(3, 1'b0, 0);
    wr(4, 1'b1, 7); wr(5, 1'b0, 3); wr(6, 1'b1, 5); wr(7, 1'b0, 5);
    wr(30, 1'b1, 0); wr(31, 1'b1, 1);

    // Table-driven timing sequence on channel 0
    cfg(0, 0, 1, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      ch_start[0] = vecs[i].start;
      @(negedge clk);
      check($sformatf("tim_pulse[%0d]", i), pulse_out[0], vecs[i].exp_pulse);
      check($sformatf("tim_valid[%0d]", i), ch_valid[0], vecs[i].exp_valid);
      check($sformatf("tim_busy[%0d]", i), ch_busy[0], vecs[i].exp_busy);
      check($sformatf("tim_done[%0d]", i), ch_done[0], vecs[i].exp_done);
      nxt();
    end
    ch_start = '0;

    // Looping: 2,3 body with two extra passes
    cfg(0, 2, 3, 2, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    ch_start[0] = 1'b1; nxt(); ch_start[0] = 1'b0;
    pat = '0; nv = 0; nl = 0; nd = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ch_valid[0]) begin pat = {pat[30:0], pulse_out[0]}; nv++; end
      nl += int'(ch_loop[0]);
      nd += int'(ch_done[0]);
      nxt();
    end
    check("loop_nsym", nv, 6);
    check("loop_pat", pat, 32'b101010);
    check("loop_pulses", nl, 2);
    check("loop_done", nd, 1);

    // Loop forever: 204 one-cycle symbols, no completion
    ch_loop_forever[0] = 1'b1;
    ch_start[0] = 1'b1; nxt(); ch_start[0] = 1'b0;
    nv = 0; nl = 0; nd = 0;
    for (int k = 1; k <= 205; k++) begin
      @(negedge clk);
      nv += int'(ch_valid[0]);
      nl += int'(ch_loop[0]);
      nd += int'(ch_done[0]);
      nxt();
    end
    check("fev_valid", nv, 204);
    check("fev_loops", nl, 102);
    check("fev_done", nd, 0);
    ch_stop[0] = 1'b1;
    @(negedge clk);
    check("fev_stop_done", ch_done[0], 0);
    nxt();
    ch_stop[0] = 1'b0;
    @(negedge clk);
    check("fev_stop_busy", ch_busy[0], 0);
    nxt();
    ch_loop_forever[0] = 1'b0;

    // Wrap: 30,31,0,1 with lengths 1,2,3,4
    wr(0, 1'b0, 2); wr(1, 1'b1, 3);
    cfg(0, 30, 1, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    ch_start[0] = 1'b1; nxt(); ch_start[0] = 1'b0;
    pat = '0; nv = 0; nd = 0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (ch_valid[0] && nv < 10) begin
`ifdef PULSE_SEQ_DEBUG_EN
        check($sformatf("wrap_pc[%0d]", nv), dbg_pc[AW-1:0], epc[nv]);
`else
        check("dbg_pc_off", dbg_pc, 0);
`endif
        pat = {pat[30:0], pulse_out[0]};
        nv++;
      end
      nd += int'(ch_done[0]);
      nxt();
    end
    check("wrap_nsym", nv, 10);
    check("wrap_pat", pat, 32'b1110001111);
    check("wrap_done", nd, 1);

    // Carrier + invert: high symbol of 8 cycles, half=1, then a low symbol of 4
    cfg(0, 4, 5, 0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    ch_carrier_half = 16'd1;
    nxt();
    @(negedge clk);
    check("car_idle", pulse_out[0], 1'b1);
    nxt();
    ch_start[0] = 1'b1; nxt(); ch_start[0] = 1'b0;
    pat = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      pat = {pat[30:0], pulse_out[0]};
      nxt();
    end
    check("car_pat", pat, 32'b10011001111111);
    cfg(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    ch_carrier_half = '0;

    // Multi-channel: same start, different presc, stop ch1 mid-symbol
    cfg(0, 6, 7, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    cfg(1, 6, 7, 0, 0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    ch_start = 2'b11; nxt(); ch_start = '0;
    @(negedge clk);
    check("mc_load_busy", ch_busy, 2'b11);
    check("mc_load_valid", ch_valid, 2'b00);
    nxt();
    @(negedge clk);
    check("mc_first_valid", ch_valid, 2'b11);
    check("mc_first_pulse", pulse_out, 2'b11);
    nxt(); nxt(); nxt();
    ch_stop = 2'b10;
    @(negedge clk);
    check("mc_stop_nodone", ch_done, 2'b00);
    nxt();
    ch_stop = '0;
    pat = '0; nd = 0; nd1 = 0; dcyc = -1;
    for (int k = 6; k <= 15; k++) begin
      @(negedge clk);
      if (k == 6) begin
        check("mc_stop_busy", ch_busy, 2'b01);
        check("mc_stop_valid", ch_valid, 2'b01);
        check("mc_stop_pulse", pulse_out, 2'b01);
      end
      if (ch_valid[0]) pat = {pat[30:0], pulse_out[0]};
      if (ch_done[0]) begin nd++; dcyc = k; end
      nd1 += int'(ch_done[1]);
      nxt();
    end
    check("mc_ch0_pat", pat, 32'b11000000);
    check("mc_ch0_done", nd, 1);
    check("mc_ch0_done_cyc", dcyc, 13);
    check("mc_ch1_done", nd1, 0);
    cfg(1, 0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Reset mid-RUN with idle level 1, then restart from start_idx
    cfg(0, 2, 3, 2, 0, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    ch_start[0] = 1'b1; nxt(); ch_start[0] = 1'b0;
    nxt(); nxt(); nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("mrst_pulse", pulse_out[0], 1'b1);
    check("mrst_busy", ch_busy[0], 0);
    check("mrst_valid", ch_valid[0], 0);
    check("mrst_dbg_pc", dbg_pc, 0);
    nxt();
    cfg(0, 5, 5, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    ch_start[0] = 1'b1; nxt(); ch_start[0] = 1'b0;
    @(negedge clk);
    check("rs_load_busy", ch_busy[0], 1);
    check("rs_load_pulse", pulse_out[0], 1'b1);
    nxt();
    @(negedge clk);
    check("rs_first_valid", ch_valid[0], 1);
    check("rs_first_pulse", pulse_out[0], 1'b0);
`ifdef PULSE_SEQ_DEBUG_EN
    check("rs_first_pc", dbg_pc[AW-1:0], 5);
`endif
    for (int k = 0; k < 5; k++) nxt();
    @(negedge clk);
    check("rs_end_busy", ch_busy[0], 0);
    check("rs_end_pulse", pulse_out[0], 1'b1);
    nxt();

    // Start held high restarts after done; stop beats a simultaneous start
    cfg(0, 2, 2, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    nxt();
    ch_start[0] = 1'b1;
    pat = '0; bpat = '0;
    for (int k = 0; k <= 6; k++) begin
      ch_stop[0] = (k == 6);
      @(negedge clk);
      pat  = {pat[30:0], ch_valid[0]};
      bpat = {bpat[30:0], ch_busy[0]};
      nxt();
    end
    ch_start[0] = 1'b0;
    ch_stop[0] = 1'b0;
    @(negedge clk);
    check("held_valid", pat, 32'b0010010);
    check("held_busy", bpat, 32'b0110110);
    check("stop_wins", ch_busy[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
